// File: rtl/multicycle_control_unit_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit_if
// Bundles every signal exchanged between the multicycle control unit and the
// datapath / memory side, so clk and rst stay the only scalar ports.
//
// Parameter:
//   CNT_W        width of the retired-instruction counter
//
// Datapath -> control unit:
//   run          leave IDLE when sampled high
//   opcode       IR opcode field (6)
//   funct        IR funct field (6)
//   zero         ALU zero flag, meaningful in EXEC
//   mem_ack      one-cycle memory completion pulse
//
// Control unit -> datapath:
//   pc_write, ir_write, mem_req, mem_we, reg_write, reg_dst, alu_src,
//   mem_to_reg   single-bit datapath controls
//   alu_op       0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
//   pc_src       0 PC+4, 1 branch target, 2 jump target
//   state        current FSM state (3)
//   busy         high while the unit is executing
//   halted       high only in HALT
//   illegal      sticky illegal-instruction flag
//   instr_count  retired-instruction counter (CNT_W)
//
// modport master : datapath side (drives the inputs of the control unit)
// modport slave  : control unit side
// ---------------------------------------------------------------------------
interface multicycle_control_unit_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ack;

  logic             pc_write;
  logic             ir_write;
  logic             mem_req;
  logic             mem_we;
  logic             reg_write;
  logic             reg_dst;
  logic             alu_src;
  logic             mem_to_reg;
  logic [2:0]       alu_op;
  logic [1:0]       pc_src;

  logic [2:0]       state;
  logic             busy;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output run, opcode, funct, zero, mem_ack,
    input  pc_write, ir_write, mem_req, mem_we, reg_write, reg_dst,
           alu_src, mem_to_reg, alu_op, pc_src,
           state, busy, halted, illegal, instr_count
  );

  modport slave (
    input  run, opcode, funct, zero, mem_ack,
    output pc_write, ir_write, mem_req, mem_we, reg_write, reg_dst,
           alu_src, mem_to_reg, alu_op, pc_src,
           state, busy, halted, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// FSM controller for a small MIPS-like multicycle datapath. Sequences
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, drives all datapath
// controls combinationally and counts retired instructions.
//
// Ports:
//   clk   single clock, all state changes on its rising edge
//   rst   synchronous, active-high reset
//   bus   multicycle_control_unit_if.slave (run/opcode/funct/zero/mem_ack in,
//         datapath controls and status out)
//
// Configuration macro:
//   CTRL_ILLEGAL_TRAP_EN  when defined, an illegal instruction traps (state
//                         TRAP, sticky illegal flag, not counted). When not
//                         defined, it retires as a NOP and illegal stays 0.
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int CNT_W = 16
) (
  input logic                          clk,
  input logic                          rst,
  multicycle_control_unit_if.slave     bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    TRAP   = 3'd7
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;
  logic             count_inc;
  logic             exec_illegal;

  logic             rtype_ok;
  logic [2:0]       rtype_alu;

  logic             c_pc_write;
  logic             c_ir_write;
  logic             c_mem_req;
  logic             c_mem_we;
  logic             c_reg_write;
  logic             c_reg_dst;
  logic             c_alu_src;
  logic             c_mem_to_reg;
  logic [2:0]       c_alu_op;
  logic [1:0]       c_pc_src;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic             illegal_q;
  logic             set_illegal;
`endif

  // R-type funct decode: translate the funct field into an ALU operation and
  // flag any funct value the datapath does not implement.
  always_comb begin
    rtype_ok  = 1'b1;
    rtype_alu = 3'd0;
    case (bus.funct)
      6'h20:   rtype_alu = 3'd0;
      6'h22:   rtype_alu = 3'd1;
      6'h24:   rtype_alu = 3'd2;
      6'h25:   rtype_alu = 3'd3;
      6'h2A:   rtype_alu = 3'd4;
      default: rtype_ok  = 1'b0;
    endcase
  end

  // Next-state and control decode. Every control defaults to 0 so that each
  // state only names what it asserts. count_inc marks exactly the transitions
  // into FETCH that retire an instruction (from EXEC, MEM or WB).
  always_comb begin
    state_d      = state_q;
    count_inc    = 1'b0;
    exec_illegal = 1'b0;
    c_pc_write   = 1'b0;
    c_ir_write   = 1'b0;
    c_mem_req    = 1'b0;
    c_mem_we     = 1'b0;
    c_reg_write  = 1'b0;
    c_reg_dst    = 1'b0;
    c_alu_src    = 1'b0;
    c_mem_to_reg = 1'b0;
    c_alu_op     = 3'd0;
    c_pc_src     = 2'd0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    set_illegal  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.run) state_d = FETCH;
      end

      FETCH: begin
        c_mem_req = 1'b1;
        if (bus.mem_ack) begin
          c_ir_write = 1'b1;
          c_pc_write = 1'b1;
          c_pc_src   = 2'd0;
          state_d    = DECODE;
        end
      end

      DECODE: begin
        state_d = EXEC;
      end

      EXEC: begin
        case (bus.opcode)
          OP_RTYPE: begin
            if (rtype_ok) begin
              c_alu_op  = rtype_alu;
              c_reg_dst = 1'b1;
              state_d   = WB;
            end else begin
              exec_illegal = 1'b1;
            end
          end
          OP_ADDI: begin
            c_alu_src = 1'b1;
            c_alu_op  = 3'd0;
            state_d   = WB;
          end
          OP_LW, OP_SW: begin
            c_alu_src = 1'b1;
            c_alu_op  = 3'd0;
            state_d   = MEM;
          end
          OP_BEQ: begin
            c_alu_op   = 3'd1;
            c_pc_src   = 2'd1;
            c_pc_write = bus.zero;
            state_d    = FETCH;
            count_inc  = 1'b1;
          end
          OP_J: begin
            c_pc_write = 1'b1;
            c_pc_src   = 2'd2;
            state_d    = FETCH;
            count_inc  = 1'b1;
          end
          OP_HALT: begin
            state_d = HALT;
          end
          default: begin
            exec_illegal = 1'b1;
          end
        endcase

        if (exec_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d     = TRAP;
          set_illegal = 1'b1;
`else
          state_d   = FETCH;
          count_inc = 1'b1;
`endif
        end
      end

      MEM: begin
        c_mem_req = 1'b1;
        c_mem_we  = (bus.opcode == OP_SW);
        if (bus.mem_ack) begin
          if (bus.opcode == OP_LW) begin
            state_d = WB;
          end else begin
            state_d   = FETCH;
            count_inc = 1'b1;
          end
        end
      end

      WB: begin
        c_reg_write  = 1'b1;
        c_mem_to_reg = (bus.opcode == OP_LW);
        state_d      = FETCH;
        count_inc    = 1'b1;
      end

      HALT:    state_d = HALT;
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and sticky flag registers. Reset wins over any pending
  // transition, including an outstanding memory request in FETCH or MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (count_inc) count_q <= count_q + 1'b1;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  // Illegal flag stays set until reset once a trap has been taken.
  always_ff @(posedge clk) begin
    if (rst)              illegal_q <= 1'b0;
    else if (set_illegal) illegal_q <= 1'b1;
  end
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  // Controls and busy/halted are forced low while rst is high so that the
  // datapath sees no request in the reset cycle itself.
  assign bus.pc_write    = c_pc_write   & ~rst;
  assign bus.ir_write    = c_ir_write   & ~rst;
  assign bus.mem_req     = c_mem_req    & ~rst;
  assign bus.mem_we      = c_mem_we     & ~rst;
  assign bus.reg_write   = c_reg_write  & ~rst;
  assign bus.reg_dst     = c_reg_dst    & ~rst;
  assign bus.alu_src     = c_alu_src    & ~rst;
  assign bus.mem_to_reg  = c_mem_to_reg & ~rst;
  assign bus.alu_op      = rst ? 3'd0 : c_alu_op;
  assign bus.pc_src      = rst ? 2'd0 : c_pc_src;

  assign bus.state       = state_q;
  assign bus.busy        = ~rst & (state_q != IDLE) & (state_q != HALT) & (state_q != TRAP);
  assign bus.halted      = ~rst & (state_q == HALT);
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
// Self-checking bench for multicycle_control_unit. Each instruction's
// expected per-cycle state/control trace is generated from the instruction
// class rules, the DUT is driven cycle by cycle and the observed trace is
// compared inline in each test task. The counter is narrowed to 8 bits so the
// wrap-around case stays short; CTRL_ILLEGAL_TRAP_EN selects the illegal
// instruction expectations.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

  localparam int CNT_W = 8;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  multicycle_control_unit_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control_unit #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  logic [2:0]  exp_state[$];
  logic [12:0] exp_ctrl[$];
  bit          exp_ack[$];
  bit          exp_noise[$];
  logic [2:0]  exp_end;
  int          exp_delta;

  logic [2:0]  obs_state[$];
  logic [12:0] obs_ctrl[$];
  logic [2:0]  obs_end;

  logic [5:0]  rfuncts[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  // Control word layout: pc_write, ir_write, mem_req, mem_we, reg_write,
  // reg_dst, alu_src, mem_to_reg, alu_op[2:0], pc_src[1:0].
  function automatic logic [12:0] ctl(bit pcw, bit irw, bit mreq, bit mwe, bit rw,
                                      bit rdst, bit asrc, bit m2r,
                                      logic [2:0] aop, logic [1:0] psrc);
    return {pcw, irw, mreq, mwe, rw, rdst, asrc, m2r, aop, psrc};
  endfunction

  function automatic logic [12:0] ctrl_now();
    return {bus.pc_write, bus.ir_write, bus.mem_req, bus.mem_we, bus.reg_write,
            bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.alu_op, bus.pc_src};
  endfunction

  function automatic int funct_alu(logic [5:0] fn);
    for (int i = 0; i < 5; i++) if (rfuncts[i] == fn) return i;
    return -1;
  endfunction

  task automatic push_exp(logic [2:0] s, logic [12:0] c, bit ack, bit noise);
    exp_state.push_back(s);
    exp_ctrl.push_back(c);
    exp_ack.push_back(ack);
    exp_noise.push_back(noise);
  endtask

  // Reference model: expected trace of one instruction starting in its first
  // FETCH cycle, given fetch/memory wait counts.
  task automatic build_expected(logic [5:0] op, logic [5:0] fn, bit z, int fw, int mw);
    int  a;
    exp_state.delete(); exp_ctrl.delete(); exp_ack.delete(); exp_noise.delete();
    for (int i = 0; i < fw; i++) push_exp(3'd1, ctl(0,0,1,0,0,0,0,0,3'd0,2'd0), 0, 0);
    push_exp(3'd1, ctl(1,1,1,0,0,0,0,0,3'd0,2'd0), 1, 0);
    push_exp(3'd2, '0, 0, 1);
    exp_end   = 3'd1;
    exp_delta = 1;
    a = funct_alu(fn);
    if (op == 6'h00 && a >= 0) begin
      push_exp(3'd3, ctl(0,0,0,0,0,1,0,0,3'(a),2'd0), 0, 1);
      push_exp(3'd5, ctl(0,0,0,0,1,0,0,0,3'd0,2'd0), 0, 1);
    end else if (op == 6'h08) begin
      push_exp(3'd3, ctl(0,0,0,0,0,0,1,0,3'd0,2'd0), 0, 1);
      push_exp(3'd5, ctl(0,0,0,0,1,0,0,0,3'd0,2'd0), 0, 1);
    end else if (op == 6'h23 || op == 6'h2B) begin
      bit sw = (op == 6'h2B);
      push_exp(3'd3, ctl(0,0,0,0,0,0,1,0,3'd0,2'd0), 0, 1);
      for (int i = 0; i < mw; i++) push_exp(3'd4, ctl(0,0,1,sw,0,0,0,0,3'd0,2'd0), 0, 0);
      push_exp(3'd4, ctl(0,0,1,sw,0,0,0,0,3'd0,2'd0), 1, 0);
      if (!sw) push_exp(3'd5, ctl(0,0,0,0,1,0,0,1,3'd0,2'd0), 0, 1);
    end else if (op == 6'h04) begin
      push_exp(3'd3, ctl(z,0,0,0,0,0,0,0,3'd1,2'd1), 0, 1);
    end else if (op == 6'h02) begin
      push_exp(3'd3, ctl(1,0,0,0,0,0,0,0,3'd0,2'd2), 0, 1);
    end else if (op == 6'h3F) begin
      push_exp(3'd3, '0, 0, 1);
      exp_end   = 3'd6;
      exp_delta = 0;
    end else begin
      push_exp(3'd3, '0, 0, 1);
      exp_end   = TRAP_EN ? 3'd7 : 3'd1;
      exp_delta = TRAP_EN ? 0 : 1;
    end
  endtask

  // Drives one instruction along the expected trace. Stray mem_ack pulses and
  // random run levels are injected where the unit must ignore them.
  task automatic applyStimulus(logic [5:0] op, logic [5:0] fn, bit z);
    obs_state.delete(); obs_ctrl.delete();
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    for (int i = 0; i < exp_state.size(); i++) begin
      bus.mem_ack = exp_ack[i] | (exp_noise[i] & 1'($urandom_range(0, 1)));
      bus.run     = 1'($urandom_range(0, 1));
      #1;
      obs_state.push_back(bus.state);
      obs_ctrl.push_back(ctrl_now());
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b0;
    #1;
    obs_end   = bus.state;
    exp_count = (exp_count + exp_delta) % (1 << CNT_W);
  endtask

  task automatic applyReset();
    bus.run = 1'b0; bus.mem_ack = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.run = 1'b1;
    @(posedge clk); #1;
    exp_count = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.run = 1'b1; bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state got %0d expected 0", bus.state); end
    checks++; if (ctrl_now() !== 13'd0) begin errors++; $display("[TB] FAIL reset_ctrl got %h expected 0", ctrl_now()); end
    checks++; if ({bus.busy, bus.halted, bus.illegal} !== 3'b000) begin errors++; $display("[TB] FAIL reset_status got %b expected 000", {bus.busy, bus.halted, bus.illegal}); end
    checks++; if (bus.instr_count !== '0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", bus.instr_count); end
    rst = 1'b0; bus.run = 1'b0; bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.state !== 3'd0) begin errors++; $display("[TB] FAIL idle_hold got %0d expected 0", bus.state); end
    bus.run = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.state !== 3'd1 || bus.busy !== 1'b1 || bus.mem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL idle_to_fetch got state %0d busy %b mem_req %b expected 1 1 1", bus.state, bus.busy, bus.mem_req);
    end
  endtask

  task automatic test_rtype_sub();
    logic [2:0] seq[6] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd5};
    build_expected(6'h00, 6'h22, 1'b0, 2, 0);
    applyStimulus(6'h00, 6'h22, 1'b0);
    for (int i = 0; i < exp_state.size(); i++) begin
      checks++; if (obs_state[i] !== seq[i]) begin errors++; $display("[TB] FAIL sub_state c%0d got %0d expected %0d", i, obs_state[i], seq[i]); end
      checks++; if (obs_ctrl[i] !== exp_ctrl[i]) begin errors++; $display("[TB] FAIL sub_ctrl c%0d got %h expected %h", i, obs_ctrl[i], exp_ctrl[i]); end
    end
    checks++; if (obs_end !== 3'd1) begin errors++; $display("[TB] FAIL sub_end got %0d expected 1", obs_end); end
    checks++; if (bus.instr_count !== 8'd1) begin errors++; $display("[TB] FAIL sub_count got %0d expected 1", bus.instr_count); end
  endtask

  task automatic test_lw_delayed();
    int mem_cycles;
    build_expected(6'h23, 6'h00, 1'b0, 0, 3);
    applyStimulus(6'h23, 6'h00, 1'b0);
    mem_cycles = 0;
    for (int i = 0; i < exp_state.size(); i++) begin
      if (obs_state[i] == 3'd4 && obs_ctrl[i][10]) mem_cycles++;
      checks++; if (obs_state[i] !== exp_state[i]) begin errors++; $display("[TB] FAIL lw_state c%0d got %0d expected %0d", i, obs_state[i], exp_state[i]); end
      checks++; if (obs_ctrl[i] !== exp_ctrl[i]) begin errors++; $display("[TB] FAIL lw_ctrl c%0d got %h expected %h", i, obs_ctrl[i], exp_ctrl[i]); end
    end
    checks++; if (mem_cycles != 4) begin errors++; $display("[TB] FAIL lw_mem_cycles got %0d expected 4", mem_cycles); end
    checks++; if (bus.instr_count !== exp_count[CNT_W-1:0]) begin errors++; $display("[TB] FAIL lw_count got %0d expected %0d", bus.instr_count, exp_count); end
  endtask

  task automatic test_beq();
    for (int k = 0; k < 2; k++) begin
      bit z = (k == 0);
      build_expected(6'h04, 6'($urandom), z, k, 0);
      applyStimulus(6'h04, exp_ctrl.size() > 0 ? 6'h11 : 6'h00, z);
      for (int i = 0; i < exp_state.size(); i++) begin
        checks++; if (obs_state[i] !== exp_state[i]) begin errors++; $display("[TB] FAIL beq%0d_state c%0d got %0d expected %0d", k, i, obs_state[i], exp_state[i]); end
        checks++; if (obs_ctrl[i] !== exp_ctrl[i]) begin errors++; $display("[TB] FAIL beq%0d_ctrl c%0d got %h expected %h", k, i, obs_ctrl[i], exp_ctrl[i]); end
      end
      checks++; if (obs_end !== exp_end) begin errors++; $display("[TB] FAIL beq%0d_end got %0d expected %0d", k, obs_end, exp_end); end
    end
    checks++; if (bus.instr_count !== exp_count[CNT_W-1:0]) begin errors++; $display("[TB] FAIL beq_count got %0d expected %0d", bus.instr_count, exp_count); end
  endtask

  task automatic test_random_mix();
    logic [5:0] ops[6] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op = ops[$urandom_range(0, 5)];
      logic [5:0] fn = (op == 6'h00) ? rfuncts[$urandom_range(0, 4)] : 6'($urandom);
      bit         z  = 1'($urandom_range(0, 1));
      build_expected(op, fn, z, $urandom_range(0, 3), $urandom_range(0, 3));
      applyStimulus(op, fn, z);
      for (int i = 0; i < exp_state.size(); i++) begin
        checks++; if (obs_state[i] !== exp_state[i]) begin errors++; $display("[TB] FAIL mix%0d_state op %h c%0d got %0d expected %0d", n, op, i, obs_state[i], exp_state[i]); end
        checks++; if (obs_ctrl[i] !== exp_ctrl[i]) begin errors++; $display("[TB] FAIL mix%0d_ctrl op %h c%0d got %h expected %h", n, op, i, obs_ctrl[i], exp_ctrl[i]); end
      end
      checks++; if (obs_end !== exp_end) begin errors++; $display("[TB] FAIL mix%0d_end got %0d expected %0d", n, obs_end, exp_end); end
      checks++; if (bus.instr_count !== exp_count[CNT_W-1:0]) begin errors++; $display("[TB] FAIL mix%0d_count got %0d expected %0d", n, bus.instr_count, exp_count); end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops[2] = '{6'h15, 6'h00};
    logic [5:0] fns[2] = '{6'h20, 6'h3B};
    for (int k = 0; k < 2; k++) begin
      build_expected(ops[k], fns[k], 1'b0, 1, 0);
      applyStimulus(ops[k], fns[k], 1'b0);
      for (int i = 0; i < exp_state.size(); i++) begin
        checks++; if (obs_state[i] !== exp_state[i]) begin errors++; $display("[TB] FAIL ill%0d_state c%0d got %0d expected %0d", k, i, obs_state[i], exp_state[i]); end
        checks++; if (obs_ctrl[i] !== exp_ctrl[i]) begin errors++; $display("[TB] FAIL ill%0d_ctrl c%0d got %h expected %h", k, i, obs_ctrl[i], exp_ctrl[i]); end
      end
      checks++; if (obs_end !== exp_end) begin errors++; $display("[TB] FAIL ill%0d_end got %0d expected %0d", k, obs_end, exp_end); end
      checks++; if (bus.illegal !== TRAP_EN) begin errors++; $display("[TB] FAIL ill%0d_flag got %b expected %b", k, bus.illegal, TRAP_EN); end
      checks++; if (bus.instr_count !== exp_count[CNT_W-1:0]) begin errors++; $display("[TB] FAIL ill%0d_count got %0d expected %0d", k, bus.instr_count, exp_count); end
      applyReset();
    end
  endtask

  task automatic test_halt();
    build_expected(6'h3F, 6'h00, 1'b0, 1, 0);
    applyStimulus(6'h3F, 6'h00, 1'b0);
    checks++; if (obs_end !== 3'd6) begin errors++; $display("[TB] FAIL halt_enter got %0d expected 6", obs_end); end
    for (int i = 0; i < 10; i++) begin
      bus.run = 1'($urandom_range(0, 1)); bus.mem_ack = 1'($urandom_range(0, 1));
      #1;
      checks++; if ({bus.state, bus.halted, bus.busy} !== {3'd6, 1'b1, 1'b0}) begin
        errors++; $display("[TB] FAIL halt_hold c%0d got state %0d halted %b busy %b expected 6 1 0", i, bus.state, bus.halted, bus.busy);
      end
      @(posedge clk); #1;
    end
    checks++; if (bus.instr_count !== exp_count[CNT_W-1:0]) begin errors++; $display("[TB] FAIL halt_count got %0d expected %0d", bus.instr_count, exp_count); end
    applyReset();
  endtask

  task automatic test_reset_mid_mem();
    for (int n = 0; n < (1 << CNT_W) - 1; n++) begin
      build_expected(6'h02, 6'h00, 1'b0, 0, 0);
      applyStimulus(6'h02, 6'h00, 1'b0);
    end
    checks++; if (bus.instr_count !== exp_count[CNT_W-1:0]) begin errors++; $display("[TB] FAIL preset_count got %0d expected %0d", bus.instr_count, exp_count); end
    bus.opcode = 6'h2B; bus.funct = 6'h00;
    bus.mem_ack = 1'b1; @(posedge clk); #1;
    bus.mem_ack = 1'b0; @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if ({bus.state, bus.mem_req, bus.mem_we} !== {3'd4, 1'b1, 1'b1}) begin
      errors++; $display("[TB] FAIL sw_mem got state %0d req %b we %b expected 4 1 1", bus.state, bus.mem_req, bus.mem_we);
    end
    rst = 1'b1; #1;
    checks++; if ({bus.mem_req, bus.busy} !== 2'b00) begin errors++; $display("[TB] FAIL rst_comb got req %b busy %b expected 0 0", bus.mem_req, bus.busy); end
    @(posedge clk); #1;
    rst = 1'b0; bus.run = 1'b0; #1;
    checks++; if ({bus.state, bus.mem_req} !== {3'd0, 1'b0} || bus.instr_count !== '0) begin
      errors++; $display("[TB] FAIL rst_mid_mem got state %0d req %b count %0d expected 0 0 0", bus.state, bus.mem_req, bus.instr_count);
    end
    bus.run = 1'b1;
    @(posedge clk); #1;
    exp_count = 0;
  endtask

  task automatic test_wrap();
    for (int n = 0; n < (1 << CNT_W) + 1; n++) begin
      build_expected(6'h02, 6'h00, 1'b0, 0, 0);
      applyStimulus(6'h02, 6'h00, 1'b0);
      if (n >= (1 << CNT_W) - 2) begin
        checks++; if (bus.instr_count !== exp_count[CNT_W-1:0]) begin
          errors++; $display("[TB] FAIL wrap_count n%0d got %0d expected %0d", n, bus.instr_count, exp_count);
        end
      end
    end
    checks++; if (bus.instr_count !== 8'd1) begin errors++; $display("[TB] FAIL wrap_after got %0d expected 1", bus.instr_count); end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    bus.run = 1'b0; bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ack = 1'b0;
    test_reset();
    test_rtype_sub();
    test_lw_delayed();
    test_beq();
    test_random_mix();
    test_illegal();
    test_halt();
    test_reset_mid_mem();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port run, input, 1: leaves IDLE when sampled high.
REQ-005 SHALL have ports opcode (input, 6) and funct (input, 6): decoded fields of the current IR.
REQ-006 SHALL have port zero, input, 1: ALU zero flag, valid in EXEC.
REQ-007 SHALL have port mem_ack, input, 1: memory completion, one-cycle pulse.
REQ-008 SHALL have control outputs, 1 bit each: pc_write, ir_write, mem_req, mem_we, reg_write, reg_dst, alu_src, mem_to_reg.
REQ-009 SHALL have port alu_op, output, 3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT.
REQ-010 SHALL have port pc_src, output, 2: 0 PC+4, 1 branch target, 2 jump target.
REQ-011 SHALL have status outputs: state (3), busy (1), halted (1), illegal (1), instr_count (CNT_W).

Function
REQ-012 SHALL use state encoding IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, TRAP=7.
REQ-013 SHALL drive all control outputs combinationally from state, opcode and funct; any control not listed for a state is 0.
REQ-014 IDLE: SHALL go to FETCH when run=1, else stay in IDLE.
REQ-015 FETCH: SHALL hold mem_req=1 until mem_ack=1; in the ack cycle SHALL drive ir_write=1, pc_write=1 and pc_src=0, then go to DECODE.
REQ-016 DECODE: SHALL last one cycle, then go to EXEC.
REQ-017 EXEC, R-type (opcode 0x00): SHALL map funct 0x20/0x22/0x24/0x25/0x2A to alu_op 0/1/2/3/4, drive reg_dst=1, then go to WB.
REQ-018 EXEC, ADDI (0x08): SHALL drive alu_src=1 and alu_op=0, then go to WB.
REQ-019 EXEC, LW (0x23) or SW (0x2B): SHALL drive alu_src=1 and alu_op=0, then go to MEM.
REQ-020 EXEC, BEQ (0x04): SHALL drive alu_op=1 and pc_src=1, drive pc_write=zero, then go to FETCH.
REQ-021 EXEC, J (0x02): SHALL drive pc_write=1 and pc_src=2, then go to FETCH.
REQ-022 EXEC, HALT (0x3F): SHALL go to HALT.
REQ-023 MEM: SHALL hold mem_req=1, with mem_we=1 for SW, until mem_ack; on ack SHALL go to WB for LW and to FETCH for SW.
REQ-024 WB: SHALL drive reg_write=1 for one cycle, with mem_to_reg=1 for LW, then go to FETCH.
REQ-025 An unlisted opcode, or an R-type with an unlisted funct, is illegal; handling is per REQ-032/033.
REQ-026 instr_count SHALL increment by 1 on every transition out of EXEC, MEM or WB into FETCH, and SHALL wrap modulo 2^CNT_W.
REQ-027 busy SHALL be 1 in all states except IDLE, HALT and TRAP; halted SHALL be 1 only in HALT.
REQ-028 HALT and TRAP SHALL be absorbing: only rst exits them.
REQ-029 A mem_ack arriving outside FETCH or MEM SHALL be ignored.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE and clear instr_count and illegal, overriding every transition, including mid-FETCH or mid-MEM with a memory request outstanding.
REQ-031 While in reset, all control outputs, busy and halted SHALL be 0.

Configuration
REQ-032 With CTRL_ILLEGAL_TRAP_EN defined: an illegal instruction in EXEC SHALL go to TRAP, set illegal=1 (sticky until rst), and SHALL NOT increment instr_count.
REQ-033 Without CTRL_ILLEGAL_TRAP_EN: an illegal instruction SHALL execute as a NOP, going EXEC->FETCH with all controls 0 and instr_count incremented; illegal SHALL be tied to 0 and TRAP is unreachable.

Verification
REQ-034 rst, run=1, mem_ack after 2 wait cycles, opcode 0x00 with funct 0x22 -> states 1,1,1,2,3(alu_op=1, reg_dst=1),5(reg_write=1),1; instr_count=1.
REQ-035 LW with mem_ack immediate in FETCH and delayed 3 cycles in MEM -> mem_req high for 4 MEM cycles, mem_we=0, then WB with mem_to_reg=1.
REQ-036 BEQ with zero=1, then BEQ with zero=0 -> pc_write=1 and pc_src=1 in the first EXEC; pc_write=0 in the second.
REQ-037 Opcode 0x3F -> state=6, halted=1, busy=0, then held for 10 cycles despite run and mem_ack toggling.
REQ-038 Opcode 0x15 -> with the macro: state=7, illegal=1, count unchanged; without it: return to FETCH, count+1.
REQ-039 rst asserted during MEM of an SW, and count preset to 0xFFFF by 65535 NOPs -> state=0, mem_req=0 and count=0 next cycle; the wrap test shows 0xFFFF->0x0000.
